// File: rtl/control_pipeline_if.sv
// rtl/control_pipeline_if.sv - decode-side and pipeline-control signal bundle for control_pipeline
interface control_pipeline_if;
    // Decode-stage control words and register fields of the instruction in ID
    logic [1:0] de_control_in;
    logic [3:0] ex_control_in;
    logic [1:0] m_control_in;
    logic [1:0] wb_control_in;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       branch_taken;

    // Stage control fields, forwarding selects and front-end hold/flush
    logic [3:0] ex_control_out;
    logic [1:0] mem_control_out;
    logic [1:0] wb_control_out;
    logic [4:0] wb_dest;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;

    // Decode side: presents the ID instruction and observes hold/flush/forwarding
    modport master (
        output de_control_in, ex_control_in, m_control_in, wb_control_in,
        output id_rs, id_rt, id_rd, branch_taken,
        input  ex_control_out, mem_control_out, wb_control_out, wb_dest,
        input  fwd_a, fwd_b, pc_write, ifid_write, ifid_flush
    );

    // Control pipeline: owns all control state after decode
    modport slave (
        input  de_control_in, ex_control_in, m_control_in, wb_control_in,
        input  id_rs, id_rt, id_rd, branch_taken,
        output ex_control_out, mem_control_out, wb_control_out, wb_dest,
        output fwd_a, fwd_b, pc_write, ifid_write, ifid_flush
    );
endinterface

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard stall, flush and forwarding
module control_pipeline (
    input  logic                clk,
    input  logic                rst_n,
    control_pipeline_if.slave   bus
);

    // Forwarding select encodings for the EX operand muxes
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // ID/EX stage register
    logic [3:0] idex_ex_q,   idex_ex_d;
    logic [1:0] idex_m_q,    idex_m_d;
    logic [1:0] idex_wb_q,   idex_wb_d;
    logic [4:0] idex_rs_q,   idex_rs_d;
    logic [4:0] idex_rt_q,   idex_rt_d;
    logic [4:0] idex_dest_q, idex_dest_d;

    // EX/MEM stage register
    logic [1:0] exmem_m_q,    exmem_m_d;
    logic [1:0] exmem_wb_q,   exmem_wb_d;
    logic [4:0] exmem_dest_q, exmem_dest_d;

    // MEM/WB stage register
    logic [1:0] memwb_wb_q,   memwb_wb_d;
    logic [4:0] memwb_dest_q, memwb_dest_d;

    // Hazard terms
    logic idex_writes_rs;
    logic idex_writes_rt;
    logic exmem_writes_rs;
    logic exmem_writes_rt;
    logic load_use_stall;
    logic branch_stall;
    logic stall;

    // Forwarding terms (compare against the operands of the instruction in EX)
    logic exmem_fwd_rs;
    logic exmem_fwd_rt;
    logic memwb_fwd_rs;
    logic memwb_fwd_rt;

    // A stage "writes r" only if it commits to the register file and r is not the zero register
    function automatic logic stage_writes(input logic       reg_write,
                                          input logic [4:0] dest,
                                          input logic [4:0] r);
        return reg_write && (dest == r) && (r != 5'd0);
    endfunction

    // Hazard detection against the instruction currently in ID
    always_comb begin
        idex_writes_rs  = stage_writes(idex_wb_q[1],  idex_dest_q,  bus.id_rs);
        idex_writes_rt  = stage_writes(idex_wb_q[1],  idex_dest_q,  bus.id_rt);
        exmem_writes_rs = stage_writes(exmem_wb_q[1], exmem_dest_q, bus.id_rs);
        exmem_writes_rt = stage_writes(exmem_wb_q[1], exmem_dest_q, bus.id_rt);

        // rt is always compared, even for immediate forms; an occasional false stall is harmless
        load_use_stall = idex_m_q[1] && (idex_writes_rs || idex_writes_rt);

        // Branches compare in ID, so any result not yet in the register file must be waited for.
        // MEM/WB needs no stall because the register file writes through to its read ports.
        branch_stall = bus.de_control_in[1] &&
                       (idex_writes_rs || idex_writes_rt ||
                        (exmem_m_q[1] && (exmem_writes_rs || exmem_writes_rt)));

        stall = load_use_stall || branch_stall;
    end

    // EX operand forwarding selects; the younger EX/MEM result has priority over MEM/WB
    always_comb begin
        // A load in EX/MEM has no data yet; that case was covered by the load-use stall
        exmem_fwd_rs = stage_writes(exmem_wb_q[1], exmem_dest_q, idex_rs_q) && !exmem_m_q[1];
        exmem_fwd_rt = stage_writes(exmem_wb_q[1], exmem_dest_q, idex_rt_q) && !exmem_m_q[1];
        memwb_fwd_rs = stage_writes(memwb_wb_q[1], memwb_dest_q, idex_rs_q);
        memwb_fwd_rt = stage_writes(memwb_wb_q[1], memwb_dest_q, idex_rt_q);

        bus.fwd_a = FWD_REGFILE;
        if (exmem_fwd_rs) begin
            bus.fwd_a = FWD_EXMEM;
        end else if (memwb_fwd_rs) begin
            bus.fwd_a = FWD_MEMWB;
        end

        bus.fwd_b = FWD_REGFILE;
        if (exmem_fwd_rt) begin
            bus.fwd_b = FWD_EXMEM;
        end else if (memwb_fwd_rt) begin
            bus.fwd_b = FWD_MEMWB;
        end
    end

    // Front-end hold and flush; a stalled branch never flushes, and nothing flushes while in reset
    always_comb begin
        bus.pc_write   = !stall;
        bus.ifid_write = !stall;
        bus.ifid_flush = rst_n && bus.de_control_in[1] && bus.branch_taken && !stall;
    end

    // Next state: ID/EX takes the decoded instruction or a bubble, later stages always advance
    always_comb begin
        idex_ex_d   = bus.ex_control_in;
        idex_m_d    = bus.m_control_in;
        idex_wb_d   = bus.wb_control_in;
        idex_rs_d   = bus.id_rs;
        idex_rt_d   = bus.id_rt;
        idex_dest_d = bus.ex_control_in[3] ? bus.id_rd : bus.id_rt;
        if (stall) begin
            idex_ex_d   = 4'd0;
            idex_m_d    = 2'd0;
            idex_wb_d   = 2'd0;
            idex_rs_d   = 5'd0;
            idex_rt_d   = 5'd0;
            idex_dest_d = 5'd0;
        end

        exmem_m_d    = idex_m_q;
        exmem_wb_d   = idex_wb_q;
        exmem_dest_d = idex_dest_q;

        memwb_wb_d   = exmem_wb_q;
        memwb_dest_d = exmem_dest_q;
    end

    // Stage registers; asynchronous reset empties the whole pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex_q    <= 4'd0;
            idex_m_q     <= 2'd0;
            idex_wb_q    <= 2'd0;
            idex_rs_q    <= 5'd0;
            idex_rt_q    <= 5'd0;
            idex_dest_q  <= 5'd0;
            exmem_m_q    <= 2'd0;
            exmem_wb_q   <= 2'd0;
            exmem_dest_q <= 5'd0;
            memwb_wb_q   <= 2'd0;
            memwb_dest_q <= 5'd0;
        end else begin
            idex_ex_q    <= idex_ex_d;
            idex_m_q     <= idex_m_d;
            idex_wb_q    <= idex_wb_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_dest_q  <= idex_dest_d;
            exmem_m_q    <= exmem_m_d;
            exmem_wb_q   <= exmem_wb_d;
            exmem_dest_q <= exmem_dest_d;
            memwb_wb_q   <= memwb_wb_d;
            memwb_dest_q <= memwb_dest_d;
        end
    end

    // Stage control fields seen by the datapath
    always_comb begin
        bus.ex_control_out  = idex_ex_q;
        bus.mem_control_out = exmem_m_q;
        bus.wb_control_out  = memwb_wb_q;
        bus.wb_dest         = memwb_dest_q;
    end

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - directed self-checking bench for control_pipeline
module tb_control_pipeline;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    control_pipeline_if bus ();

    control_pipeline dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] EX_R  = 4'b1010;
    localparam logic [3:0] EX_LW = 4'b0100;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [1:0] de, input logic [3:0] ex, input logic [1:0] m,
                         input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic tk);
        bus.de_control_in = de;
        bus.ex_control_in = ex;
        bus.m_control_in  = m;
        bus.wb_control_in = wb;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.branch_taken  = tk;
        #1;
    endtask

    task automatic nop();
        drive(2'b00, 4'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            nop();
            nxt();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ex"},    {4'd0, bus.ex_control_out},  8'h00);
        chk({tag, ".mem"},   {6'd0, bus.mem_control_out}, 8'h00);
        chk({tag, ".wb"},    {6'd0, bus.wb_control_out},  8'h00);
        chk({tag, ".dest"},  {3'd0, bus.wb_dest},         8'h00);
        chk({tag, ".fwd_a"}, {6'd0, bus.fwd_a},           8'h00);
        chk({tag, ".fwd_b"}, {6'd0, bus.fwd_b},           8'h00);
        chk({tag, ".pc_w"},  {7'd0, bus.pc_write},        8'h01);
        chk({tag, ".ifid_w"},{7'd0, bus.ifid_write},      8'h01);
        chk({tag, ".flush"}, {7'd0, bus.ifid_flush},      8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;

        // Reset with random ID inputs, branch forced taken to exercise flush suppression
        drive(2'b11, 4'($urandom), 2'($urandom), 2'($urandom),
              5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        nxt();
        drive(2'b11, 4'($urandom), 2'($urandom), 2'($urandom),
              5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
        chk_reset_outputs("rst_clk");
        nxt();
        rst_n = 1'b1;

        // R-type latency: decode in N, EX at N+1, MEM at N+2, WB at N+3
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd1, 5'd2, 5'd5, 1'b0);
        nxt();
        nop();
        chk("lat.ex", {4'd0, bus.ex_control_out}, 8'h0a);
        nxt();
        nop();
        chk("lat.ex_n2", {4'd0, bus.ex_control_out}, 8'h00);
        chk("lat.wb_n2", {6'd0, bus.wb_control_out}, 8'h00);
        nxt();
        nop();
        chk("lat.wb",   {6'd0, bus.wb_control_out}, 8'h03);
        chk("lat.dest", {3'd0, bus.wb_dest},        8'h05);
        drain();

        // Load-use: LW r3 then ADD rs=3 stalls exactly one cycle
        drive(2'b00, EX_LW, 2'b10, 2'b10, 5'd1, 5'd3, 5'd0, 1'b0);
        chk("lu.pre_pc", {7'd0, bus.pc_write}, 8'h01);
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd3, 5'd6, 5'd7, 1'b0);
        chk("lu.pc",     {7'd0, bus.pc_write},   8'h00);
        chk("lu.ifid",   {7'd0, bus.ifid_write}, 8'h00);
        chk("lu.flush",  {7'd0, bus.ifid_flush}, 8'h00);
        nxt();
        chk("lu.bubble", {4'd0, bus.ex_control_out}, 8'h00);
        chk("lu.mem",    {6'd0, bus.mem_control_out}, 8'h02);
        chk("lu.rel_pc", {7'd0, bus.pc_write},   8'h01);
        nxt();
        nop();
        chk("lu.add_ex", {4'd0, bus.ex_control_out}, 8'h0a);
        chk("lu.fwd_a",  {6'd0, bus.fwd_a},          8'h01);
        chk("lu.fwd_b",  {6'd0, bus.fwd_b},          8'h00);
        chk("lu.wb_dest",{3'd0, bus.wb_dest},        8'h03);
        drain();

        // Forwarding priority: EX/MEM beats MEM/WB
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd1, 5'd2, 5'd4, 1'b0);
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd1, 5'd2, 5'd4, 1'b0);
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd4, 5'd4, 5'd8, 1'b0);
        chk("pri.pc", {7'd0, bus.pc_write}, 8'h01);
        nxt();
        nop();
        chk("pri.fwd_a", {6'd0, bus.fwd_a}, 8'h02);
        chk("pri.fwd_b", {6'd0, bus.fwd_b}, 8'h02);
        drain();

        // Same with a NOP in between: MEM/WB supplies both operands
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd1, 5'd2, 5'd4, 1'b0);
        nxt();
        nop();
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd4, 5'd4, 5'd8, 1'b0);
        nxt();
        nop();
        chk("mw.fwd_a", {6'd0, bus.fwd_a}, 8'h01);
        chk("mw.fwd_b", {6'd0, bus.fwd_b}, 8'h01);
        drain();

        // Register 0 is never a hazard or a forwarding source
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd1, 5'd2, 5'd0, 1'b0);
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd0, 5'd0, 5'd9, 1'b0);
        chk("r0.pc", {7'd0, bus.pc_write}, 8'h01);
        nxt();
        nop();
        chk("r0.fwd_a", {6'd0, bus.fwd_a}, 8'h00);
        chk("r0.fwd_b", {6'd0, bus.fwd_b}, 8'h00);
        drain();
        drive(2'b00, EX_LW, 2'b10, 2'b10, 5'd1, 5'd0, 5'd0, 1'b0);
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd0, 5'd0, 5'd9, 1'b0);
        chk("r0.lw_pc", {7'd0, bus.pc_write}, 8'h01);
        drain();

        // Branch after load: two stall cycles, then a single flush
        drive(2'b00, EX_LW, 2'b10, 2'b10, 5'd1, 5'd2, 5'd0, 1'b0);
        nxt();
        drive(2'b11, 4'd0, 2'd0, 2'd0, 5'd2, 5'd7, 5'd0, 1'b1);
        chk("bl.s1_pc",    {7'd0, bus.pc_write},   8'h00);
        chk("bl.s1_flush", {7'd0, bus.ifid_flush}, 8'h00);
        nxt();
        chk("bl.s2_pc",    {7'd0, bus.pc_write},   8'h00);
        chk("bl.s2_flush", {7'd0, bus.ifid_flush}, 8'h00);
        nxt();
        chk("bl.rel_pc",   {7'd0, bus.pc_write},   8'h01);
        chk("bl.flush",    {7'd0, bus.ifid_flush}, 8'h01);
        nxt();
        nop();
        chk("bl.flush_off",{7'd0, bus.ifid_flush}, 8'h00);
        drain();

        // Branch after ALU producer: one stall cycle
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd1, 5'd2, 5'd9, 1'b0);
        nxt();
        drive(2'b10, 4'd0, 2'd0, 2'd0, 5'd9, 5'd0, 5'd0, 1'b1);
        chk("ba.s1_pc",    {7'd0, bus.pc_write},   8'h00);
        chk("ba.s1_flush", {7'd0, bus.ifid_flush}, 8'h00);
        nxt();
        chk("ba.rel_pc",   {7'd0, bus.pc_write},   8'h01);
        chk("ba.flush",    {7'd0, bus.ifid_flush}, 8'h01);
        nxt();
        drain();

        // Reset asserted during a load-use stall
        drive(2'b00, EX_LW, 2'b10, 2'b10, 5'd1, 5'd3, 5'd0, 1'b0);
        nxt();
        drive(2'b00, EX_R, 2'b00, 2'b11, 5'd3, 5'd6, 5'd7, 1'b0);
        chk("rms.pc_before", {7'd0, bus.pc_write},       8'h00);
        chk("rms.ex_before", {4'd0, bus.ex_control_out}, 8'h04);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rms");
        nxt();
        rst_n = 1'b1;
        nop();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Consumes the control words produced by the decode-stage control unit and carries them down the ID/EX, EX/MEM and MEM/WB pipeline registers, together with register-number tags. It detects load-use and branch-operand hazards, inserts bubbles, and drives PC/IF-ID hold and IF/ID flush. It also generates the EX-stage operand forwarding selects. It sits beside the datapath pipeline registers and is the single owner of all control state after decode.

## Interface
- No parameters. Register numbers are 5 bits; control field widths are fixed.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `de_control_in` in 2: decode-stage field. Bit1 = branch. Bit0 = 1 for BEQ, 0 for BNE.
- `ex_control_in` in 4: {RegDest, AluSrc, AluOp[1:0]}. RegDest = 1 selects rd, otherwise rt.
- `m_control_in` in 2: bit1 = load (memory read), bit0 = store.
- `wb_control_in` in 2: bit1 = RegWrite, bit0 = 1 for ALU result, 0 for memory data.
- `id_rs`, `id_rt`, `id_rd` in 5 each: register fields of the instruction in ID.
- `branch_taken` in 1: ID comparator result, valid only when `de_control_in[1]` = 1.
- `ex_control_out` out 4: ID/EX EX field.
- `mem_control_out` out 2: EX/MEM M field.
- `wb_control_out` out 2: MEM/WB WB field.
- `wb_dest` out 5: MEM/WB destination register.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write data.
- `pc_write`, `ifid_write` out 1: 0 holds PC and IF/ID.
- `ifid_flush` out 1: 1 zeroes IF/ID on the next edge.

## Operation
- **Stage registers.**
  - ID/EX holds {ex, m, wb, rs, rt, dest}. `dest` = RegDest ? `id_rd` : `id_rt`, computed at ID/EX load.
  - EX/MEM holds {m, wb, dest}.
  - MEM/WB holds {wb, dest}.
- **Writer definition.** A stage "writes r" when its wb[1] = 1, its dest = r, and r ≠ 0.
- **Load-use stall.** Asserted when ID/EX m[1] = 1 and ID/EX writes `id_rs`, or writes `id_rt` with the ID instruction not AluSrc-only. Decided: always compare rt; a false stall is acceptable.
- **Branch stall.** Asserted when `de_control_in[1]` = 1 and either:
  - ID/EX writes `id_rs` or `id_rt`; or
  - EX/MEM m[1] = 1 and EX/MEM writes `id_rs` or `id_rt`.
  - The register file is write-through, so MEM/WB producers need no stall.
- **stall** = load-use stall OR branch stall (combinational).
- **On stall:**
  - `pc_write` = 0 and `ifid_write` = 0.
  - ID/EX loads a bubble: all fields 0.
  - EX/MEM and MEM/WB advance normally.
- **Flush.** `ifid_flush` = `de_control_in[1]` & `branch_taken` & ~stall. A branch is never taken while it is stalled.
- **fwd_a.**
  - 10 if EX/MEM writes ID/EX rs and EX/MEM m[1] = 0.
  - Otherwise 01 if MEM/WB writes ID/EX rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- **fwd_b.** Same rule using ID/EX rt.
- **Opcode handling.** Unknown opcodes arrive as all-zero control and travel as bubbles.

## Timing
- **Reset.** Asynchronous on `rst_n` = 0. All stage registers clear to 0. Outputs after reset:
  - `ex_control_out` = 0, `mem_control_out` = 0, `wb_control_out` = 0, `wb_dest` = 0.
  - `fwd_a` = `fwd_b` = 00.
  - `pc_write` = 1, `ifid_write` = 1, `ifid_flush` = 0.
- **Reset release.** Registers start loading on the first rising edge with `rst_n` = 1.
- **Latency.** Control decoded in cycle N appears on:
  - `ex_control_out` in cycle N+1;
  - `mem_control_out` in cycle N+2;
  - `wb_control_out` / `wb_dest` in cycle N+3.
- **Combinational outputs.** Stall, flush and forwarding outputs are purely combinational from current register state and ID inputs, valid in the same cycle. No output depends combinationally on itself.
- **Stall duration.**
  - Load-use: exactly 1 cycle.
  - Branch after ALU producer: 1 cycle.
  - Branch after load: 2 cycles.
- **Reset mid-stall.** Pipeline empties and `pc_write` returns to 1 immediately (asynchronous).
- **Simultaneous stall and branch_taken.** Stall wins; the flush fires on the cycle the stall releases.

## Test plan
- **Reset.**
  - Stimulus: hold `rst_n` = 0 with random inputs.
  - Response: all outputs at reset values.
  - Stimulus: deassert `rst_n`, present R-type {ex=1010, m=00, wb=11}, `id_rd` = 5.
  - Response: `ex_control_out` = 1010 next cycle; `wb_control_out` = 11 and `wb_dest` = 5 three cycles after decode.
- **Load-use.**
  - Stimulus: LW r3 (ex=0100, m=10, wb=10, rt=3), then ADD with rs=3.
  - Response: one cycle with `pc_write` = `ifid_write` = 0 and a bubble in ID/EX. Next cycle ADD enters EX with `fwd_a` = 01.
- **Forwarding priority.**
  - Stimulus: ADD r4, then ADD r4, then ADD rs=4 rt=4.
  - Response: third instruction in EX shows `fwd_a` = `fwd_b` = 10.
  - Stimulus: same sequence with a NOP as the second instruction.
  - Response: `fwd_a` = `fwd_b` = 01.
- **Register 0.**
  - Stimulus: ADD writing r0, then a consumer of r0.
  - Response: no stall; `fwd_a` = `fwd_b` = 00.
- **Branch after load.**
  - Stimulus: LW r2, then BEQ (de=11) rs=2, with `branch_taken` = 1.
  - Response: 2 stall cycles with `ifid_flush` = 0; then `ifid_flush` = 1 for 1 cycle.
- **Reset mid-stall.**
  - Stimulus: pull `rst_n` low during the load-use stall cycle.
  - Response: `pc_write` = 1 immediately; all stage outputs 0.
